fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage of the MIPS core.
- Owns the program counter and drives the combinational instruction memory address.
- Captures the returned word into an IF/ID pipeline register for the decoder.
- Handles sequential PC+4 advance, decoder back-pressure (stall), and branch redirect with wrong-path flush.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- PC_STEP, 32'd4, byte increment per sequential fetch.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_addr  output  32  byte address to instruction memory; equals current PC, combinational from pc register.
- instr_data  input  32  instruction word returned combinationally by memory for instr_addr.
- id_ready  input  1  decoder can accept the IF/ID contents this cycle.
- branch_taken  input  1  one-cycle redirect request from execute.
- branch_pc_plus4  input  32  PC+4 of the branch instruction.
- branch_offset  input  16  signed word offset from the branch immediate.
- if_id_valid  output  1  IF/ID register holds a real instruction.
- if_id_instr  output  32  registered instruction word.
- if_id_pc_plus4  output  32  registered PC+4 of that instruction.
- fetch_count  output  32  number of instructions accepted into IF/ID since reset.
- misaligned  output  1  sticky flag: PC ever loaded with addr[1:0] != 0.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc_plus4=0, fetch_count=0, misaligned=0. instr_addr follows pc immediately.
- Memory latency is 0: instr_data is valid in the same cycle instr_addr is driven. Fetch-to-IF/ID latency is 1 cycle.
- stall = if_id_valid & ~id_ready.
- Per rising edge, priority order:
  1. Redirect (branch_taken=1):
     - pc <= branch_pc_plus4 + ({{14{off[15]}}, off, 2'b00}), with off = branch_offset; 32-bit wrap.
     - if_id_valid <= 0, squashing the wrong-path instruction. The instruction at the current pc is discarded.
     - Overrides stall.
     - if_id_instr and if_id_pc_plus4 are don't-care but held.
  2. Stall: pc, IF/ID and fetch_count all hold.
  3. Advance:
     - pc <= pc + PC_STEP, 32-bit wrap at 0xFFFFFFFC -> 0x00000000.
     - if_id_instr <= instr_data; if_id_pc_plus4 <= pc + PC_STEP; if_id_valid <= 1.
     - fetch_count <= fetch_count + 1, wrapping modulo 2^32.
- Decoder acceptance: the decoder consumes IF/ID when if_id_valid & id_ready.
- Valid bubble: if_id_valid=0 with id_ready=0 is not a stall; the fetch proceeds.
- misaligned: set on any edge where the next pc has [1:0] != 0 (reachable only via a misaligned branch_pc_plus4). Cleared only by reset. Fetch continues; memory returns 0, which is fetched as a nop.
- branch_taken is sampled only at clock edges. If held high for N cycles, it redirects N times, each from the current branch inputs.
- Reset mid-stall or mid-redirect: all state returns to reset values immediately. There is no pending-redirect memory.
- No combinational path from id_ready or branch_taken to instr_addr.

Decomposition:
- Shared package mips_pkg:
  - opcode/funct constants (OP_R, OP_ADDI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OPR_ADD, OPR_SUB).
  - NOP_INSTR = 32'h0.
  - PC_STEP.
  - Function branch_target(pc_plus4, off16).
- One sub-module, if_id_reg: IF/ID pipeline register with load/hold/flush controls and the valid bit. pc logic and counters stay in fetch_unit.

Test Plan:
- Reset then release, id_ready=1, memory holding the standard 7-word test program -> cycle 0 instr_addr=0x0; after edge 1: if_id_instr=0x20000003, if_id_pc_plus4=4, if_id_valid=1, instr_addr=4, fetch_count=1.
- Stall: after 3 fetches drop id_ready for 2 cycles -> instr_addr stays 12, if_id_pc_plus4 stays 12, fetch_count stays 3; raise id_ready -> resumes at 12 -> 16.
- Redirect: branch_taken=1, branch_pc_plus4=28, branch_offset=16'hFFFB (-5) -> next instr_addr=8, if_id_valid=0 for one cycle; following edge if_id_pc_plus4=12, valid=1.
- Redirect during stall: id_ready=0, if_id_valid=1, branch_taken=1 with target 0x40 -> pc=0x40, if_id_valid=0, fetch_count unchanged.
- Wrap and misalignment:
  - RESET_PC=32'hFFFFFFFC, advance once -> instr_addr=0.
  - Redirect with branch_pc_plus4=0x102, offset=0 -> instr_addr=0x102, misaligned=1 and stays 1 across later aligned fetches.
- Async reset mid-run: assert rst_n=0 between edges while valid=1 -> outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode/funct encodings, the canonical nop,
// the sequential fetch step, and the branch target calculation.
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] OPR_ADD = 6'h20;
    localparam logic [5:0] OPR_SUB = 6'h22;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Branch target = PC+4 of the branch plus the sign-extended word offset.
    // Wraps modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                  input logic [15:0] off16);
        return pc_plus4 + {{14{off16[15]}}, off16, 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush clears only the valid bit; the payload is
// held so a squashed slot costs no data-path toggling.
module if_id_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] next_instr,
    input  logic [31:0] next_pc_plus4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4
);
    import mips_pkg::*;

    // Flush wins over load so a redirect always squashes the wrong-path word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'd0;
        end else if (flush) begin
            valid    <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= next_instr;
            pc_plus4 <= next_pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the zero-latency instruction
// memory address, and fills the IF/ID register. Redirect beats stall beats
// sequential advance.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = mips_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    input  logic        id_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc_plus4,
    input  logic [15:0] branch_offset,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] fetch_count,
    output logic        misaligned
);
    import mips_pkg::*;

    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic [31:0] pc_next;
    logic        stall;
    logic        advance;

    // Address comes straight from the register: no path from id_ready or
    // branch_taken reaches the memory address.
    assign instr_addr = pc;
    assign pc_seq     = pc + PC_STEP;

    // An empty IF/ID slot never stalls, even if the decoder is not ready.
    assign stall   = if_id_valid & ~id_ready;
    assign advance = ~branch_taken & ~stall;

    // Next-PC selection in priority order: redirect, stall, sequential.
    always_comb begin
        pc_next = pc_seq;
        if (branch_taken) begin
            pc_next = branch_target(branch_pc_plus4, branch_offset);
        end else if (stall) begin
            pc_next = pc;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= RESET_PC;
        else        pc <= pc_next;
    end

    // Count instructions accepted into IF/ID; wraps modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       fetch_count <= 32'd0;
        else if (advance) fetch_count <= fetch_count + 32'd1;
    end

    // Sticky misalignment flag; fetch keeps going, memory hands back nops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    misaligned <= 1'b0;
        else if (pc_next[1:0] != 2'b00) misaligned <= 1'b1;
    end

    if_id_reg u_if_id (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (advance),
        .flush        (branch_taken),
        .next_instr   (instr_data),
        .next_pc_plus4(pc_seq),
        .valid        (if_id_valid),
        .instr        (if_id_instr),
        .pc_plus4     (if_id_pc_plus4)
    );

endmodule
